// File: rtl/instr_fetch_unit.sv
// Instruction fetch/assembly: reads 1-3 program-memory bytes at pc and hands the
// assembled instruction to the decoder. Build option: IFETCH_ZERO_FILL_EN clears operands on opcode capture.
module instr_fetch_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_load,
    output logic [DATA_W-1:0] fetch_opcode,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              flush,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_opcode,
    output logic [DATA_W-1:0] instr_op1,
    output logic [DATA_W-1:0] instr_op2,
    output logic [1:0]        instr_len,
    output logic [1:0]        debug_state
);

    // Handshake: instr_valid is high only in HOLD, where every instruction output is
    // frozen; a transfer happens on a rising edge with instr_valid & instr_ready & !flush.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [1:0]  len_now;
    logic        cap_en;

    // Must stay identical to the program counter's length table.
    function automatic logic [1:0] len_of(input logic [DATA_W-1:0] op);
        case (op)
            DATA_W'(8'h78), DATA_W'(8'h80), DATA_W'(8'hC0), DATA_W'(8'h81),
            DATA_W'(8'h82), DATA_W'(8'h84), DATA_W'(8'h85), DATA_W'(8'h87): len_of = 2'd2;
            DATA_W'(8'h83):                                                  len_of = 2'd1;
            default:                                                         len_of = 2'd3;
        endcase
    endfunction

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cap_en      = 1'b0;
        mem_rd      = 1'b0;
        mem_addr    = '0;
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        len_now     = (idx == 2'd0) ? len_of(mem_data) : instr_len;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                mem_rd    = 1'b1;
                mem_addr  = pc + ADDR_W'(idx);
                state_nxt = CAPT;
            end
            CAPT: begin
                cap_en = 1'b1;
                if (idx + 2'd1 == len_now) begin
                    state_nxt = HOLD;
                end else begin
                    idx_nxt   = idx + 2'd1;
                    state_nxt = REQ;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                pc_load     = instr_ready & ~flush;
                if (instr_ready) begin
                    idx_nxt   = 2'd0;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Flush wins over capture and handshake; data for an aborted read is dropped.
        if (flush && state != IDLE) begin
            state_nxt = REQ;
            idx_nxt   = 2'd0;
            cap_en    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 2'd0;
            instr_opcode <= '0;
            instr_op1    <= '0;
            instr_op2    <= '0;
            instr_len    <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (cap_en) begin
                case (idx)
                    2'd0: begin
                        instr_opcode <= mem_data;
                        instr_len    <= len_now;
`ifdef IFETCH_ZERO_FILL_EN
                        instr_op1    <= '0;
                        instr_op2    <= '0;
`endif
                    end
                    2'd1:    instr_op1 <= mem_data;
                    2'd2:    instr_op2 <= mem_data;
                    default: ;
                endcase
            end
        end
    end

    assign fetch_opcode = instr_opcode;
    assign debug_state  = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stimulus pushes expected addresses and
// instructions into queues; a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] pc = 6'd0;
    logic       pc_load;
    logic [7:0] fetch_opcode;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic       flush = 1'b0;
    logic       instr_valid;
    logic       instr_ready = 1'b0;
    logic [7:0] instr_opcode, instr_op1, instr_op2;
    logic [1:0] instr_len;
    logic [1:0] debug_state;

    logic [7:0]  mem [64];
    logic        pc_set = 1'b0;
    logic [5:0]  pc_set_val = 6'd0;
    logic [25:0] exp_q[$];
    logic [5:0]  addr_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          pc_load_cnt = 0;
    int          base;

`ifdef IFETCH_ZERO_FILL_EN
    localparam logic [7:0] KEEP1 = 8'h00;
    localparam logic [7:0] KEEP2 = 8'h00;
`else
    localparam logic [7:0] KEEP1 = 8'hAA;
    localparam logic [7:0] KEEP2 = 8'hBB;
`endif

    instr_fetch_unit #(.ADDR_W(6), .DATA_W(8)) dut (
        .clock(clock), .reset(reset), .pc(pc), .pc_load(pc_load),
        .fetch_opcode(fetch_opcode), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .flush(flush), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_op1(instr_op1), .instr_op2(instr_op2), .instr_len(instr_len),
        .debug_state(debug_state)
    );

    // clock / reset block
    always #5 clock = ~clock;

    // Program counter model and registered program memory.
    function automatic logic [1:0] pc_len(input logic [7:0] op);
        if (op == 8'h83) return 2'd1;
        if (op == 8'h78 || op == 8'h80 || op == 8'hC0 || op == 8'h81 ||
            op == 8'h82 || op == 8'h84 || op == 8'h85 || op == 8'h87) return 2'd2;
        return 2'd3;
    endfunction

    always @(posedge clock) begin
        if (pc_set) pc <= pc_set_val;
        else if (pc_load) pc <= pc + {4'b0000, pc_len(fetch_opcode)};
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (pc_load) pc_load_cnt++;
            if (mem_rd && addr_q.size() > 0) chk("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
            if (instr_valid && instr_ready && !flush && exp_q.size() > 0)
                chk("instr", 32'({instr_opcode, instr_op1, instr_op2, instr_len}), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] p);
        reset = 1'b1;
        flush = 1'b0;
        instr_ready = 1'b0;
        pc_set = 1'b1;
        pc_set_val = p;
        tick(2);
        pc_set = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h83;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && (exp_q.size() + addr_q.size()) > 0; i++) tick(1);
        chk(name, 32'(exp_q.size() + addr_q.size()), 32'd0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, 32'(instr_valid), 32'd0);
        chk({name, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_pc_load"}, 32'(pc_load), 32'd0);
        chk({name, "_bytes"}, 32'({fetch_opcode, instr_op1, instr_op2, instr_len}), 32'd0);
        chk({name, "_state"}, 32'(debug_state), 32'd0);
    endtask

    initial begin
        // 1-byte instruction straight out of reset
        do_reset(6'd0);
        chk_reset_outputs("rst");
        addr_q.push_back(6'd0);
        addr_q.push_back(6'd1);
        exp_q.push_back({8'h83, 8'h00, 8'h00, 2'd1});
        instr_ready = 1'b1;
        base = pc_load_cnt;
        reset = 1'b0;
        tick(2);
        chk("p1_valid_c2", 32'(instr_valid), 32'd0);
        tick(1);
        chk("p1_valid_c3", 32'(instr_valid), 32'd1);
        tick(1);
        chk("p1_pc_load_cnt", 32'(pc_load_cnt - base), 32'd1);
        chk("p1_next_addr", 32'({mem_rd, mem_addr}), 32'({1'b1, 6'd1}));
        wait_drain("p1_drain");

        // 2-byte instruction, decoder stalls for 5 cycles
        do_reset(6'd10);
        mem[10] = 8'h80;
        mem[11] = 8'h2A;
        addr_q.push_back(6'd10);
        addr_q.push_back(6'd11);
        addr_q.push_back(6'd12);
        exp_q.push_back({8'h80, 8'h2A, 8'h00, 2'd2});
        reset = 1'b0;
        tick(4);
        chk("p2_valid_early", 32'(instr_valid), 32'd0);
        tick(1);
        chk("p2_valid", 32'(instr_valid), 32'd1);
        base = pc_load_cnt;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("p2_frozen", 32'({instr_valid, instr_opcode, instr_op1, instr_len}),
                32'({1'b1, 8'h80, 8'h2A, 2'd2}));
        end
        chk("p2_no_pc_load", 32'(pc_load_cnt - base), 32'd0);
        instr_ready = 1'b1;
        wait_drain("p2_drain");

        // address wrap 62, 63, 0
        do_reset(6'd62);
        mem[62] = 8'h10;
        mem[63] = 8'h11;
        mem[0] = 8'h12;
        addr_q.push_back(6'd62);
        addr_q.push_back(6'd63);
        addr_q.push_back(6'd0);
        addr_q.push_back(6'd1);
        exp_q.push_back({8'h10, 8'h11, 8'h12, 2'd3});
        instr_ready = 1'b1;
        reset = 1'b0;
        wait_drain("p3_drain");

        // flush in byte-1 capture of a 3-byte instruction, pc rewritten to 20
        do_reset(6'd5);
        mem[5] = 8'h01;
        mem[6] = 8'hAA;
        mem[7] = 8'hBB;
        addr_q.push_back(6'd5);
        addr_q.push_back(6'd6);
        addr_q.push_back(6'd20);
        exp_q.push_back({8'h83, 8'h00, 8'h00, 2'd1});
        instr_ready = 1'b1;
        base = pc_load_cnt;
        reset = 1'b0;
        tick(4);
        chk("p4_in_capt", 32'(debug_state), 32'd2);
        flush = 1'b1;
        pc_set = 1'b1;
        pc_set_val = 6'd20;
        #1;
        chk("p4_flush_outs", 32'({instr_valid, pc_load}), 32'd0);
        tick(1);
        flush = 1'b0;
        pc_set = 1'b0;
        chk("p4_req_after", 32'({debug_state, mem_rd, mem_addr}), 32'({2'd1, 1'b1, 6'd20}));
        chk("p4_no_pc_load", 32'(pc_load_cnt - base), 32'd0);
        wait_drain("p4_drain");

        // operand retention vs zero fill
        do_reset(6'd30);
        mem[30] = 8'h01;
        mem[31] = 8'hAA;
        mem[32] = 8'hBB;
        mem[33] = 8'h83;
        for (int a = 30; a <= 34; a++) addr_q.push_back(6'(a));
        exp_q.push_back({8'h01, 8'hAA, 8'hBB, 2'd3});
        exp_q.push_back({8'h83, KEEP1, KEEP2, 2'd1});
        instr_ready = 1'b1;
        reset = 1'b0;
        wait_drain("p5_drain");

        // flush beats handshake, then asynchronous reset in HOLD
        do_reset(6'd40);
        reset = 1'b0;
        tick(3);
        chk("p6_hold", 32'(instr_valid), 32'd1);
        base = pc_load_cnt;
        instr_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("p6_flush_prio", 32'(pc_load), 32'd0);
        tick(1);
        flush = 1'b0;
        instr_ready = 1'b0;
        chk("p6_refetch", 32'({instr_valid, mem_rd, mem_addr}), 32'({1'b0, 1'b1, 6'd40}));
        tick(2);
        chk("p6_hold_again", 32'(instr_valid), 32'd1);
        chk("p6_no_pc_load", 32'(pc_load_cnt - base), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        tick(2);
        chk("p6_in_reset", 32'({instr_valid, pc_load, debug_state}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
